// File: rtl/sha256_job_scheduler.sv
// Dispatches one mining job across NUM_CORES sha256_double cores, each scanning its own
// slice of the nonce space, and reports the first nonce found or full exhaustion.
module sha256_job_scheduler #(
    parameter int          NUM_CORES = 4,
    parameter logic [32:0] STRIDE    = 33'h1_0000_0000 / 33'(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [11:0][7:0]            job_data,
    input  logic [7:0][31:0]            job_state,
    input  logic [31:0][7:0]            job_target,
    input  logic [31:0]                 job_nonce_start,
    output logic [NUM_CORES-1:0]        core_in_valid,
    output logic [11:0][7:0]            core_data,
    output logic [7:0][31:0]            core_state,
    output logic [31:0][7:0]            core_target,
    output logic [NUM_CORES-1:0][31:0]  core_nonce_base,
    input  logic [NUM_CORES-1:0]        core_out_valid,
    input  logic [NUM_CORES-1:0][31:0]  core_nonce_found,
    input  logic [NUM_CORES-1:0]        core_exhausted,
    output logic                        res_valid,
    output logic [31:0]                 res_nonce,
    output logic                        res_exhausted,
    output logic                        busy,
    output logic [31:0]                 job_cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // With a single core the stride is exactly 2^32, which wraps to 0 in 32 bits.
    localparam logic [31:0] STRIDE_MOD = STRIDE[31:0];

    logic                       r_rst_meta;
    logic                       r_rst_n;
    logic [2:0]                 r_state;
    logic [11:0][7:0]           r_core_data;
    logic [7:0][31:0]           r_core_state;
    logic [31:0][7:0]           r_core_target;
    logic [NUM_CORES-1:0][31:0] r_nonce_base;
    logic [NUM_CORES-1:0]       r_mask;
    logic [31:0]                r_job_cycles;
    logic [31:0]                r_res_nonce;
    logic                       r_res_exhausted;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_found;
    logic [31:0]                w_found_nonce;
    logic [NUM_CORES-1:0]       w_mask_next;
    logic                       w_mask_done;
    logic [31:0]                w_cycles_inc;
    logic [NUM_CORES-1:0][31:0] w_nonce_base;

    // NOTE: assertion is asynchronous, release is delayed two edges so no flop sees
    // the deassertion close to its clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    assign w_ready      = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_accept     = job_valid && w_ready;
    assign w_mask_next  = r_mask | core_exhausted;
    assign w_mask_done  = &w_mask_next;
    assign w_cycles_inc = (&r_job_cycles) ? r_job_cycles : r_job_cycles + 32'd1;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
        assign w_nonce_base[g] = job_nonce_start + STRIDE_MOD * 32'(g);
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_found       = 1'b0;
        w_found_nonce = '0;
        // Scanning downwards leaves the lowest asserted index as the winner.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_out_valid[i]) begin
                w_found       = 1'b1;
                w_found_nonce = core_nonce_found[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state         <= S_IDLE;
            r_core_data     <= '0;
            r_core_state    <= '0;
            r_core_target   <= '0;
            r_nonce_base    <= '0;
            r_mask          <= '0;
            r_job_cycles    <= '0;
            r_res_nonce     <= '0;
            r_res_exhausted <= 1'b0;
        end else if (w_accept) begin
            // A new job wins over anything the cores report on the same edge.
            r_state       <= S_LAUNCH;
            r_core_data   <= job_data;
            r_core_state  <= job_state;
            r_core_target <= job_target;
            r_nonce_base  <= w_nonce_base;
            r_mask        <= '0;
            r_job_cycles  <= '0;
        end else begin
            case (r_state)
                S_LAUNCH: begin
                    r_state      <= S_SETTLE;
                    r_job_cycles <= w_cycles_inc;
                end
                S_SETTLE: begin
                    r_state      <= S_RUN;
                    r_job_cycles <= w_cycles_inc;
                end
                S_RUN: begin
                    r_job_cycles <= w_cycles_inc;
                    if (w_found) begin
                        r_state         <= S_DONE;
                        r_res_nonce     <= w_found_nonce;
                        r_res_exhausted <= 1'b0;
                    end else begin
                        r_mask <= w_mask_next;
                        if (w_mask_done) begin
                            r_state         <= S_DONE;
                            r_res_nonce     <= '0;
                            r_res_exhausted <= 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_IDLE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign job_ready       = w_ready;
    assign busy            = (r_state != S_IDLE);
    assign res_valid       = (r_state == S_DONE);
    assign core_in_valid   = {NUM_CORES{r_state == S_LAUNCH}};
    assign core_data       = r_core_data;
    assign core_state      = r_core_state;
    assign core_target     = r_core_target;
    assign core_nonce_base = r_nonce_base;
    assign res_nonce       = r_res_nonce;
    assign res_exhausted   = r_res_exhausted;
    assign job_cycles      = r_job_cycles;

endmodule
